updown_counter_ext: RTL and testbench
=====================================

Name: updown_counter_ext

Overview:
- Parametrised successor to the team's 8-bit loadable up/down counter.
- Adds:
  - configurable width and step size
  - programmable lower/upper limits with wrap or saturate mode
  - an enable prescaler
  - boundary event pulse and sticky flag
  - compare-match output
- Used as a general event/timer counter behind the TT user I/O wrapper; registers come from tile-level inputs.

Parameters:
- WIDTH, 8, counter and limit/compare width (2..32).
- STEP_W, 4, width of step input.
- PRESC_W, 4, width of prescaler divide value.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- dir_up  in  1  1 = up, 0 = down.
- step  in  STEP_W  increment/decrement magnitude.
- presc  in  PRESC_W  advance once every presc+1 enabled cycles.
- sat_mode  in  1  1 = saturate at limits, 0 = wrap.
- limit_lo  in  WIDTH  lower bound.
- limit_hi  in  WIDTH  upper bound.
- cmp_val  in  WIDTH  compare value.
- clr_sticky  in  1  clears bnd_sticky.
- count  out  WIDTH  current count, registered.
- bnd_evt  out  1  one-cycle pulse, boundary wrap/saturation occurred on this update.
- bnd_sticky  out  1  latched boundary flag.
- cmp_match  out  1  combinational, count == cmp_val.
- cfg_err  out  1  combinational, limit_lo > limit_hi.

Behaviour:
- Reset (rst_n low, async): count = 0, prescaler counter = 0, bnd_evt = 0, bnd_sticky = 0. Outputs take these values immediately, independent of clk.
- Priority per edge: load > advance > hold.
- Load:
  - count <= load_val verbatim, even if outside [limit_lo, limit_hi].
  - Prescaler counter <= 0.
  - bnd_evt <= 0. A load cancels any advance in that cycle.
- Prescaler:
  - With en = 1 and no load, pc increments each cycle.
  - When pc >= presc, a tick occurs and pc <= 0.
  - presc = 0 gives a tick every enabled cycle.
  - en = 0 freezes pc.
  - A presc change takes effect against the current pc; the >= compare avoids a lockout.
- Advance (tick, cfg_err = 0, step != 0): arithmetic uses WIDTH+1 bits, with no modular wrap.
  - Up, count + step <= limit_hi: count <= count + step.
  - Up, count + step > limit_hi (includes count already above hi): wrap mode count <= limit_lo; sat mode count <= limit_hi. Boundary event in both modes.
  - Down, count >= limit_lo + step: count <= count - step.
  - Down otherwise (includes count already below lo): wrap mode count <= limit_hi; sat mode count <= limit_lo. Boundary event in both modes.
  - Wrap lands exactly on the opposite limit; the remainder is discarded.
  - Saturate while already at the limit still asserts a boundary event each tick.
- Hold cases: step = 0 or cfg_err = 1 means no change, no event, and the prescaler still runs.
- limit_lo == limit_hi: any nonzero step is a boundary event; count sits at that limit.
- bnd_evt: registered, high exactly in the cycle after the edge that performed a boundary update.
- bnd_sticky: set on a boundary update, cleared by clr_sticky. Simultaneous set and clear: set wins.
- cmp_match and cfg_err are purely combinational from count and inputs; no latency.
- Full WIDTH range: limit_lo = 0 and limit_hi = 2^WIDTH-1 behaves as a plain modular counter only for step = 1. For larger steps, wrap lands on the limit per the rules above.

Test Plan:
- Reset mid-count (count = 0x37, assert rst_n low between edges) -> count = 0 and bnd_sticky = 0 immediately; pc restarts at 0 after release.
- Wrap up: WIDTH = 8, lo = 10, hi = 20, step = 3, presc = 0, load 18, en = 1, dir_up = 1 -> count 18, 10(bnd_evt), 13, 16, 19, 10(bnd_evt).
- Saturate down: sat_mode = 1, lo = 5, step = 4, load 12, dir_up = 0 -> 8, 5(evt), 5(evt). bnd_sticky stays 1 until clr_sticky; clr_sticky in the same cycle as evt leaves sticky 1.
- Prescaler: presc = 2, step = 1, lo = 0, hi = 255, load 0 -> count increments on every 3rd enabled cycle. Dropping en for 2 cycles stretches the gap to 5.
- Load priority: load = 1 with en = 1 and a tick pending, load_val = 0xF0 (above hi = 20) -> count = 0xF0, no evt. The next up tick gives count = lo (wrap, evt).
- Config error and compare: lo = 30, hi = 20 -> cfg_err = 1, count frozen. With cmp_val = count, cmp_match = 1 in the same cycle; step = 0 also freezes with no evt.

Source files
------------

// File: rtl/updown_counter_ext.sv
// Parametrised loadable up/down counter with limits, wrap/saturate, prescaler,
// boundary event/sticky flags and compare match.
module updown_counter_ext #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STEP_W  = 4,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               en,
  input  logic               dir_up,
  input  logic [STEP_W-1:0]  step,
  input  logic [PRESC_W-1:0] presc,
  input  logic               sat_mode,
  input  logic [WIDTH-1:0]   limit_lo,
  input  logic [WIDTH-1:0]   limit_hi,
  input  logic [WIDTH-1:0]   cmp_val,
  input  logic               clr_sticky,
  output logic [WIDTH-1:0]   count,
  output logic               bnd_evt,
  output logic               bnd_sticky,
  output logic               cmp_match,
  output logic               cfg_err
);

  // Wide enough that count+step and lo+step never overflow.
  localparam int unsigned AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [WIDTH-1:0]   r_count;
  logic [PRESC_W-1:0] r_pc;
  logic               r_bnd_evt;
  logic               r_bnd_sticky;

  logic               w_tick;
  logic               w_adv;
  logic               w_bnd;
  logic [AW-1:0]      w_cnt_x;
  logic [AW-1:0]      w_step_x;
  logic [AW-1:0]      w_lo_x;
  logic [AW-1:0]      w_hi_x;
  logic [AW-1:0]      w_sum;
  logic [AW-1:0]      w_lo_plus;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_count_d;
  logic [PRESC_W-1:0] w_pc_d;

  assign cfg_err   = (limit_lo > limit_hi);
  assign cmp_match = (r_count == cmp_val);

  assign w_cnt_x   = {{(AW-WIDTH){1'b0}}, r_count};
  assign w_step_x  = {{(AW-STEP_W){1'b0}}, step};
  assign w_lo_x    = {{(AW-WIDTH){1'b0}}, limit_lo};
  assign w_hi_x    = {{(AW-WIDTH){1'b0}}, limit_hi};
  assign w_sum     = w_cnt_x + w_step_x;
  assign w_lo_plus = w_lo_x + w_step_x;
  // Only used when count >= lo + step, so the narrow subtraction cannot underflow.
  assign w_diff    = r_count - w_step_x[WIDTH-1:0];

  // >= rather than == so a presc reduced below the current pc still ticks.
  assign w_tick = en && (r_pc >= presc);
  assign w_adv  = !load && w_tick && !cfg_err && (step != '0);

  always_comb begin
    w_count_d = r_count;
    w_bnd     = 1'b0;
    w_pc_d    = r_pc;
    if (load) begin
      w_count_d = load_val;
      w_pc_d    = '0;
    end else begin
      if (en) begin
        w_pc_d = w_tick ? '0 : r_pc + 1'b1;
      end
      if (w_adv) begin
        if (dir_up) begin
          if (w_sum <= w_hi_x) begin
            w_count_d = w_sum[WIDTH-1:0];
          end else begin
            w_count_d = sat_mode ? limit_hi : limit_lo;
            w_bnd     = 1'b1;
          end
        end else begin
          if (w_cnt_x >= w_lo_plus) begin
            w_count_d = w_diff;
          end else begin
            w_count_d = sat_mode ? limit_lo : limit_hi;
            w_bnd     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_pc         <= '0;
      r_bnd_evt    <= 1'b0;
      r_bnd_sticky <= 1'b0;
    end else begin
      r_count   <= w_count_d;
      r_pc      <= w_pc_d;
      r_bnd_evt <= w_bnd;
      if (w_bnd) begin
        r_bnd_sticky <= 1'b1;
      end else if (clr_sticky) begin
        r_bnd_sticky <= 1'b0;
      end
    end
  end

  assign count      = r_count;
  assign bnd_evt    = r_bnd_evt;
  assign bnd_sticky = r_bnd_sticky;

endmodule

// File: tb/tb_updown_counter_ext.sv
// Directed self-checking bench for updown_counter_ext (WIDTH=8, STEP_W=4, PRESC_W=4).
module tb_updown_counter_ext;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       dir_up;
  logic [3:0] step;
  logic [3:0] presc;
  logic       sat_mode;
  logic [7:0] limit_lo;
  logic [7:0] limit_hi;
  logic [7:0] cmp_val;
  logic       clr_sticky;
  logic [7:0] count;
  logic       bnd_evt;
  logic       bnd_sticky;
  logic       cmp_match;
  logic       cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  updown_counter_ext #(
    .WIDTH  (8),
    .STEP_W (4),
    .PRESC_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_val  (load_val),
    .en        (en),
    .dir_up    (dir_up),
    .step      (step),
    .presc     (presc),
    .sat_mode  (sat_mode),
    .limit_lo  (limit_lo),
    .limit_hi  (limit_hi),
    .cmp_val   (cmp_val),
    .clr_sticky(clr_sticky),
    .count     (count),
    .bnd_evt   (bnd_evt),
    .bnd_sticky(bnd_sticky),
    .cmp_match (cmp_match),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check count and bnd_evt after one edge.
  task automatic step_chk(input string tag, input logic [7:0] exp_cnt, input logic exp_evt);
    tick();
    check({tag, "_cnt"}, 32'(count), 32'(exp_cnt));
    check({tag, "_evt"}, 32'(bnd_evt), 32'(exp_evt));
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; dir_up = 1'b1; step = '0;
    presc = '0; sat_mode = 1'b0; limit_lo = '0; limit_hi = '0; cmp_val = '0;
    clr_sticky = 1'b0;

    #3;
    check("rst_cnt", 32'(count), 32'h0);
    check("rst_evt", 32'(bnd_evt), 32'h0);
    check("rst_sticky", 32'(bnd_sticky), 32'h0);
    check("rst_cmp", 32'(cmp_match), 32'h1);
    check("rst_cfg", 32'(cfg_err), 32'h0);
    tick();
    rst_n = 1'b1;

    // Wrap up: 18 -> 10(evt) -> 13 -> 16 -> 19 -> 10(evt)
    limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd3; presc = 4'd0; dir_up = 1'b1;
    load = 1'b1; load_val = 8'd18;
    step_chk("wu_load", 8'd18, 1'b0);
    load = 1'b0; en = 1'b1;
    step_chk("wu1", 8'd10, 1'b1);
    check("wu1_sticky", 32'(bnd_sticky), 32'h1);
    step_chk("wu2", 8'd13, 1'b0);
    step_chk("wu3", 8'd16, 1'b0);
    step_chk("wu4", 8'd19, 1'b0);
    step_chk("wu5", 8'd10, 1'b1);
    en = 1'b0; clr_sticky = 1'b1;
    tick();
    check("wu_clr", 32'(bnd_sticky), 32'h0);
    clr_sticky = 1'b0;

    // Saturate down: 12 -> 8 -> 5(evt) -> 5(evt); clr with evt keeps sticky
    sat_mode = 1'b1; limit_lo = 8'd5; step = 4'd4; dir_up = 1'b0;
    load = 1'b1; load_val = 8'd12;
    step_chk("sd_load", 8'd12, 1'b0);
    load = 1'b0; en = 1'b1;
    step_chk("sd1", 8'd8, 1'b0);
    step_chk("sd2", 8'd5, 1'b1);
    clr_sticky = 1'b1;
    step_chk("sd3", 8'd5, 1'b1);
    check("sd3_sticky", 32'(bnd_sticky), 32'h1);
    en = 1'b0; clr_sticky = 1'b0;
    step_chk("sd_hold", 8'd5, 1'b0);
    check("sd_hold_sticky", 32'(bnd_sticky), 32'h1);
    clr_sticky = 1'b1;
    tick();
    check("sd_clr", 32'(bnd_sticky), 32'h0);
    clr_sticky = 1'b0;

    // Prescaler divide-by-3, then en low for two cycles stretches the gap to 5
    sat_mode = 1'b0; limit_lo = 8'd0; limit_hi = 8'd255; step = 4'd1; presc = 4'd2;
    dir_up = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'd0;
    step_chk("ps_load", 8'd0, 1'b0);
    load = 1'b0;
    step_chk("ps1", 8'd0, 1'b0);
    step_chk("ps2", 8'd0, 1'b0);
    step_chk("ps3", 8'd1, 1'b0);
    step_chk("ps4", 8'd1, 1'b0);
    step_chk("ps5", 8'd1, 1'b0);
    step_chk("ps6", 8'd2, 1'b0);
    step_chk("ps7", 8'd2, 1'b0);
    en = 1'b0;
    step_chk("ps8", 8'd2, 1'b0);
    step_chk("ps9", 8'd2, 1'b0);
    en = 1'b1;
    step_chk("ps10", 8'd2, 1'b0);
    step_chk("ps11", 8'd3, 1'b0);

    // Load beats a pending tick; value above hi then wraps to lo
    limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd3; presc = 4'd0;
    load = 1'b1; load_val = 8'hF0;
    step_chk("lp_load", 8'hF0, 1'b0);
    load = 1'b0;
    step_chk("lp_wrap", 8'd10, 1'b1);

    // Async reset between edges
    en = 1'b0; load = 1'b1; load_val = 8'h37;
    step_chk("ar_load", 8'h37, 1'b0);
    load = 1'b0;
    check("ar_pre_sticky", 32'(bnd_sticky), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cnt", 32'(count), 32'h0);
    check("ar_sticky", 32'(bnd_sticky), 32'h0);
    limit_lo = 8'd0; limit_hi = 8'd255; step = 4'd1; presc = 4'd2; en = 1'b1;
    #1 rst_n = 1'b1;
    step_chk("ar1", 8'd0, 1'b0);
    step_chk("ar2", 8'd0, 1'b0);
    step_chk("ar3", 8'd1, 1'b0);

    // Config error freezes; cmp_match is combinational; step=0 freezes
    presc = 4'd0; en = 1'b0; load = 1'b1; load_val = 8'd25;
    step_chk("ce_load", 8'd25, 1'b0);
    load = 1'b0; en = 1'b1; limit_lo = 8'd30; limit_hi = 8'd20; cmp_val = 8'd25;
    #1;
    check("ce_cfg", 32'(cfg_err), 32'h1);
    check("ce_cmp", 32'(cmp_match), 32'h1);
    step_chk("ce_hold", 8'd25, 1'b0);
    cmp_val = 8'd26;
    #1;
    check("ce_nocmp", 32'(cmp_match), 32'h0);
    limit_lo = 8'd10; limit_hi = 8'd30; step = 4'd0;
    #1;
    check("ce_ok", 32'(cfg_err), 32'h0);
    step_chk("z_hold", 8'd25, 1'b0);
    step = 4'd1;
    step_chk("z_run", 8'd26, 1'b0);
    check("z_cmp", 32'(cmp_match), 32'h1);

    // lo == hi: every nonzero step is a boundary event
    limit_lo = 8'd15; limit_hi = 8'd15; step = 4'd2;
    step_chk("eq1", 8'd15, 1'b1);
    step_chk("eq2", 8'd15, 1'b1);

    en = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
